br_comp_arbiter: RTL and testbench
==================================

Name: br_comp_arbiter

Overview:
- Shares one BranchComp instance between two requesters: requester 0 is the branch-resolution unit and requester 1 is the SLT/SLTI(U) unit.
- Accepts a comparison request on a valid/ready channel per requester, with round-robin arbitration between them.
- Latches the granted operands and drives them to the comparator for one cycle.
- Captures brEq/brLt and returns them on a single tagged response channel, held until accepted.

Parameters:
- DATA_W, 32, operand width (rs1/rs2/imm and comparator data ports).
- RR_INIT, 0, requester that holds priority after reset (0 or 1).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has a request.
- req0_ready  out  1  requester 0 request accepted this cycle.
- req0_brSel  in  2  comparator mode (00 signed rs1/rs2, 01 unsigned, 10 signed rs1/imm, 11 unsigned rs1/imm).
- req0_rs1  in  DATA_W  operand A.
- req0_rs2  in  DATA_W  operand B (reg).
- req0_imm  in  DATA_W  operand B (imm).
- req1_valid, req1_ready, req1_brSel, req1_rs1, req1_rs2, req1_imm: same as requester 0, for requester 1.
- cmp_brSel  out  2  to comparator.
- cmp_rs1  out  DATA_W  to comparator.
- cmp_rs2  out  DATA_W  to comparator.
- cmp_imm  out  DATA_W  to comparator.
- cmp_brEq  in  1  from comparator.
- cmp_brLt  in  1  from comparator.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer takes result.
- resp_id  out  1  requester that owns the result.
- resp_brEq  out  1  captured brEq.
- resp_brLt  out  1  captured brLt.

Behaviour:
- FSM states: IDLE, CMP, RESP. Reset state is IDLE.
- Reset values: all outputs 0; operand registers 0; priority pointer = RR_INIT. Reset is asynchronous and aborts any operation in any state; a requester whose request was in flight re-presents it, because its valid is still held.
- IDLE:
  - Grant goes to the single valid requester.
  - If both are valid, grant goes to the priority-pointer requester.
  - reqN_ready is asserted combinationally for the granted N only; there is no ready without valid.
  - On handshake: latch brSel/rs1/rs2/imm and the id, set the pointer to the other requester, go to CMP.
- CMP (exactly 1 cycle):
  - cmp_* are driven from the latched registers.
  - At the clock edge, cmp_brEq/cmp_brLt are captured into resp_brEq/resp_brLt; go to RESP.
- Outside CMP, cmp_brSel/rs1/rs2/imm are driven to 0.
- RESP:
  - resp_valid = 1; resp_id, resp_brEq and resp_brLt are stable until the handshake.
  - On resp_valid & resp_ready, go to IDLE. The next request can be accepted on the following cycle.
- Latency: request handshake at cycle N -> resp_valid at cycle N+2. Maximum throughput is one result per 3 cycles when resp_ready is tied high.
- Flags pass through unmodified; the arbiter never reinterprets brEq/brLt semantics.
- Fairness: with both requesters continuously valid, grants strictly alternate.
- No request is accepted in CMP or RESP (req0_ready = req1_ready = 0).
- Requesters must hold valid and operands stable until ready; the arbiter does not register unaccepted requests.

Optional Feature:
- Macro BR_COMP_ARB_PERF_EN.
- When defined: adds outputs perf_grant0 and perf_grant1 (32-bit each) and perf_conflict (32-bit).
  - perf_grant0/perf_grant1 count handshakes per requester.
  - perf_conflict counts IDLE cycles with both valid.
  - All three saturate at 0xFFFFFFFF and are reset to 0 by rst_n.
- When undefined: these ports and counters do not exist, and the remaining logic is identical.

Decomposition:
- Shared package (br_comp_pkg): BRSEL_S_RR=2'b00, BRSEL_U_RR=2'b01, BRSEL_S_RI=2'b10, BRSEL_U_RI=2'b11; FSM state encoding (IDLE/CMP/RESP); requester id constants REQ_BR=0, REQ_SLT=1.
- One natural sub-module, rr_arb2: a 2-way round-robin grant with pointer register, with inputs valid0/valid1/advance and outputs gnt0/gnt1.
- BranchComp stays external, instantiated beside the arbiter at the top level.

Test Plan:
- Reset: rst_n low mid-CMP with req0 valid -> FSM IDLE, resp_valid=0, all cmp_* = 0. After release, req0 is regranted and a response arrives 2 cycles after the handshake.
- Single requester: req0 brSel=01, rs1=5, rs2=5 -> req0_ready at N; cmp_rs1=5 at N+1; resp_valid at N+2 with resp_id=0, resp_brEq=1.
- Imm path: req1 brSel=11, rs1=7, rs2=0xDEAD, imm=3 -> cmp_imm=3, cmp_brSel=11 in CMP; resp_id=1 with the flags the comparator returned.
- Contention: both valid continuously, RR_INIT=0, resp_ready=1 -> grant sequence 0,1,0,1 and one response every 3 cycles.
- Backpressure: resp_ready=0 for 5 cycles in RESP -> resp_valid and flags stable, both readies 0; resp_ready=1 -> IDLE next cycle.
- With BR_COMP_ARB_PERF_EN: 4 contended grants -> perf_grant0=2, perf_grant1=2, perf_conflict≥4.

Source files
------------

// File: rtl/br_comp_pkg.sv
// Shared constants for the BranchComp arbiter: comparator modes, FSM encoding, requester ids.
package br_comp_pkg;

  localparam logic [1:0] BRSEL_S_RR = 2'b00;
  localparam logic [1:0] BRSEL_U_RR = 2'b01;
  localparam logic [1:0] BRSEL_S_RI = 2'b10;
  localparam logic [1:0] BRSEL_U_RI = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic REQ_BR  = 1'b0;
  localparam logic REQ_SLT = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; the pointer names the requester that wins a tie.
// Combinational grant, pointer moves to the loser's side on advance.
module rr_arb2 #(
  parameter int RR_INIT = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic valid0,
  input  logic valid1,
  input  logic advance,
  output logic gnt0,
  output logic gnt1
);

  logic ptr;

  assign gnt0 = valid0 & (~valid1 | ~ptr);
  assign gnt1 = valid1 & (~valid0 |  ptr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= (RR_INIT != 0);
    end else if (advance) begin
      ptr <= gnt0;
    end
  end

endmodule

// File: rtl/br_comp_arbiter.sv
// Shares one BranchComp between branch unit (id 0) and SLT unit (id 1); result at handshake+2, held until resp_ready.
// Optional counters perf_grant0/perf_grant1/perf_conflict exist only when BR_COMP_ARB_PERF_EN is defined.
module br_comp_arbiter
  import br_comp_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int RR_INIT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [1:0]        req0_brSel,
  input  logic [DATA_W-1:0] req0_rs1,
  input  logic [DATA_W-1:0] req0_rs2,
  input  logic [DATA_W-1:0] req0_imm,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [1:0]        req1_brSel,
  input  logic [DATA_W-1:0] req1_rs1,
  input  logic [DATA_W-1:0] req1_rs2,
  input  logic [DATA_W-1:0] req1_imm,
  output logic [1:0]        cmp_brSel,
  output logic [DATA_W-1:0] cmp_rs1,
  output logic [DATA_W-1:0] cmp_rs2,
  output logic [DATA_W-1:0] cmp_imm,
  input  logic              cmp_brEq,
  input  logic              cmp_brLt,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_id,
  output logic              resp_brEq,
`ifdef BR_COMP_ARB_PERF_EN
  output logic              resp_brLt,
  output logic [31:0]       perf_grant0,
  output logic [31:0]       perf_grant1,
  output logic [31:0]       perf_conflict
`else
  output logic              resp_brLt
`endif
);

  state_t            state, state_nxt;
  logic              idle;
  logic              gnt0, gnt1, hs;
  logic [1:0]        lat_brSel;
  logic [DATA_W-1:0] lat_rs1, lat_rs2, lat_imm;

  assign idle = (state == IDLE);

  // Requests are masked outside IDLE so ready can never rise in CMP/RESP.
  rr_arb2 #(.RR_INIT(RR_INIT)) u_rr_arb2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid0  (req0_valid & idle),
    .valid1  (req1_valid & idle),
    .advance (hs),
    .gnt0    (gnt0),
    .gnt1    (gnt1)
  );

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign hs         = gnt0 | gnt1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    resp_valid = 1'b0;
    cmp_brSel  = '0;
    cmp_rs1    = '0;
    cmp_rs2    = '0;
    cmp_imm    = '0;
    case (state)
      IDLE: begin
        if (hs) state_nxt = CMP;
      end
      CMP: begin
        cmp_brSel = lat_brSel;
        cmp_rs1   = lat_rs1;
        cmp_rs2   = lat_rs2;
        cmp_imm   = lat_imm;
        state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_brSel <= '0;
      lat_rs1   <= '0;
      lat_rs2   <= '0;
      lat_imm   <= '0;
      resp_id   <= REQ_BR;
      resp_brEq <= 1'b0;
      resp_brLt <= 1'b0;
    end else begin
      if (hs) begin
        lat_brSel <= gnt1 ? req1_brSel : req0_brSel;
        lat_rs1   <= gnt1 ? req1_rs1   : req0_rs1;
        lat_rs2   <= gnt1 ? req1_rs2   : req0_rs2;
        lat_imm   <= gnt1 ? req1_imm   : req0_imm;
        resp_id   <= gnt1 ? REQ_SLT    : REQ_BR;
      end
      if (state == CMP) begin
        resp_brEq <= cmp_brEq;
        resp_brLt <= cmp_brLt;
      end
    end
  end

`ifdef BR_COMP_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_grant0   <= '0;
      perf_grant1   <= '0;
      perf_conflict <= '0;
    end else begin
      if (gnt0 && perf_grant0 != 32'hFFFF_FFFF) perf_grant0 <= perf_grant0 + 32'd1;
      if (gnt1 && perf_grant1 != 32'hFFFF_FFFF) perf_grant1 <= perf_grant1 + 32'd1;
      if (idle && req0_valid && req1_valid && perf_conflict != 32'hFFFF_FFFF)
        perf_conflict <= perf_conflict + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_br_comp_arbiter.sv
// Directed bench for br_comp_arbiter; a behavioural BranchComp stands in for the real comparator.
module tb_br_comp_arbiter;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic req0_valid, req1_valid, req0_ready, req1_ready;
  logic [1:0] req0_brSel, req1_brSel, cmp_brSel;
  logic [W-1:0] req0_rs1, req0_rs2, req0_imm, req1_rs1, req1_rs2, req1_imm;
  logic [W-1:0] cmp_rs1, cmp_rs2, cmp_imm, cmp_b;
  logic cmp_brEq, cmp_brLt;
  logic resp_valid, resp_ready, resp_id, resp_brEq, resp_brLt;
`ifdef BR_COMP_ARB_PERF_EN
  logic [31:0] perf_grant0, perf_grant1, perf_conflict;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Stand-in comparator: brSel[1] picks imm, brSel[0] selects unsigned.
  always_comb begin
    cmp_b    = cmp_brSel[1] ? cmp_imm : cmp_rs2;
    cmp_brEq = (cmp_rs1 == cmp_b);
    cmp_brLt = cmp_brSel[0] ? (cmp_rs1 < cmp_b) : ($signed(cmp_rs1) < $signed(cmp_b));
  end

  br_comp_arbiter #(.DATA_W(W), .RR_INIT(0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_brSel (req0_brSel),
    .req0_rs1   (req0_rs1),
    .req0_rs2   (req0_rs2),
    .req0_imm   (req0_imm),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_brSel (req1_brSel),
    .req1_rs1   (req1_rs1),
    .req1_rs2   (req1_rs2),
    .req1_imm   (req1_imm),
    .cmp_brSel  (cmp_brSel),
    .cmp_rs1    (cmp_rs1),
    .cmp_rs2    (cmp_rs2),
    .cmp_imm    (cmp_imm),
    .cmp_brEq   (cmp_brEq),
    .cmp_brLt   (cmp_brLt),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_brEq  (resp_brEq),
`ifdef BR_COMP_ARB_PERF_EN
    .resp_brLt     (resp_brLt),
    .perf_grant0   (perf_grant0),
    .perf_grant1   (perf_grant1),
    .perf_conflict (perf_conflict)
`else
    .resp_brLt  (resp_brLt)
`endif
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 0; req0_brSel = 0; req0_rs1 = 0; req0_rs2 = 0; req0_imm = 0;
    req1_valid = 0; req1_brSel = 0; req1_rs1 = 0; req1_rs2 = 0; req1_imm = 0;
    resp_ready = 1'b0;
    cyc(); cyc();
    chk("rst_resp_valid", {31'd0, resp_valid}, 0);
    chk("rst_cmp_rs1", cmp_rs1, 0);
    chk("rst_resp_flags", {30'd0, resp_brEq, resp_brLt}, 0);
    #2 rst_n = 1'b1;
    cyc();

    // Contention, RR_INIT=0: grants 0,1,0,1, one response every 3 cycles.
    req0_valid = 1; req0_brSel = 2'b00; req0_rs1 = 32'd10; req0_rs2 = 32'd10;
    req1_valid = 1; req1_brSel = 2'b01; req1_rs1 = 32'd1;  req1_rs2 = 32'd2;
    resp_ready = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("cont_rdy0", {31'd0, req0_ready}, (i % 2 == 0) ? 1 : 0);
      chk("cont_rdy1", {31'd0, req1_ready}, (i % 2 == 1) ? 1 : 0);
      cyc();
      if (i == 3) begin req0_valid = 0; req1_valid = 0; end
      chk("cont_cmp_rs1", cmp_rs1, (i % 2 == 0) ? 32'd10 : 32'd1);
      chk("cont_cmp_rdy", {30'd0, req0_ready, req1_ready}, 0);
      cyc();
      chk("cont_resp_valid", {31'd0, resp_valid}, 1);
      chk("cont_resp_id", {31'd0, resp_id}, (i % 2 == 1) ? 1 : 0);
      chk("cont_resp_flags", {30'd0, resp_brEq, resp_brLt}, (i % 2 == 0) ? 2 : 1);
      cyc();
      chk("cont_back_idle", {31'd0, resp_valid}, 0);
    end
`ifdef BR_COMP_ARB_PERF_EN
    chk("perf_grant0", perf_grant0, 2);
    chk("perf_grant1", perf_grant1, 2);
    chk("perf_conflict_ge4", {31'd0, (perf_conflict >= 32'd4)}, 1);
`endif

    // Reset mid-CMP with req0 held valid, then regrant and full response.
    req0_valid = 1; req0_brSel = 2'b01; req0_rs1 = 32'd5; req0_rs2 = 32'd5; req0_imm = 0;
    cyc();
    chk("abort_cmp_rs1", cmp_rs1, 5);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_resp_valid", {31'd0, resp_valid}, 0);
    chk("abort_cmp_rs1_zero", cmp_rs1, 0);
    chk("abort_cmp_sel_zero", {30'd0, cmp_brSel}, 0);
    cyc();
    chk("abort_hold_resp", {31'd0, resp_valid}, 0);
    #2 rst_n = 1'b1;
    #1;
    chk("single_rdy0", {31'd0, req0_ready}, 1);
    cyc();
    req0_valid = 0;
    chk("single_cmp_rs1", cmp_rs1, 5);
    chk("single_cmp_sel", {30'd0, cmp_brSel}, 1);
    chk("single_n1_no_resp", {31'd0, resp_valid}, 0);
    cyc();
    chk("single_resp_valid", {31'd0, resp_valid}, 1);
    chk("single_resp_id", {31'd0, resp_id}, 0);
    chk("single_resp_flags", {30'd0, resp_brEq, resp_brLt}, 2);
    cyc();
    chk("single_idle", {31'd0, resp_valid}, 0);

    // Immediate path, requester 1, unsigned 7 vs 3.
    req1_valid = 1; req1_brSel = 2'b11; req1_rs1 = 32'd7; req1_rs2 = 32'hDEAD; req1_imm = 32'd3;
    #1;
    chk("imm_rdy1", {31'd0, req1_ready}, 1);
    cyc();
    req1_valid = 0;
    chk("imm_cmp_imm", cmp_imm, 3);
    chk("imm_cmp_sel", {30'd0, cmp_brSel}, 3);
    chk("imm_cmp_rs2", cmp_rs2, 32'hDEAD);
    cyc();
    chk("imm_resp_id", {31'd0, resp_id}, 1);
    chk("imm_resp_flags", {30'd0, resp_brEq, resp_brLt}, 0);
    cyc();

    // Backpressure: signed -5 < 3 from req0 while req1 also waits.
    resp_ready = 0;
    req0_valid = 1; req0_brSel = 2'b00; req0_rs1 = 32'hFFFF_FFFB; req0_rs2 = 32'd3;
    req1_valid = 1; req1_brSel = 2'b01; req1_rs1 = 32'd1; req1_rs2 = 32'd2;
    #1;
    chk("bp_rdy", {30'd0, req0_ready, req1_ready}, 2);
    cyc();
    req0_valid = 0;
    cyc();
    for (int i = 0; i < 5; i++) begin
      chk("bp_resp_valid", {31'd0, resp_valid}, 1);
      chk("bp_resp_id", {31'd0, resp_id}, 0);
      chk("bp_resp_flags", {30'd0, resp_brEq, resp_brLt}, 1);
      chk("bp_rdy_low", {30'd0, req0_ready, req1_ready}, 0);
      cyc();
    end
    resp_ready = 1;
    cyc();
    chk("bp_release_idle", {31'd0, resp_valid}, 0);
    chk("bp_next_grant1", {30'd0, req0_ready, req1_ready}, 1);
    req1_valid = 0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
